// File: rtl/multicycle_subtractor.sv
// Multi-cycle unsigned subtractor: diff = a - b - borrow_in, CHUNK bits per
// clock with the borrow carried between cycles. Valid/ready on both sides.
module multicycle_subtractor #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CHUNK:0]   chunk_res;
  logic             last_chunk;

  assign last_chunk = (k_q == KW'(NCHUNK - 1));

  // One chunk of the subtraction; the extra top bit is the chunk borrow-out.
  always_comb begin
    chunk_res = {1'b0, a_q[int'(k_q)*CHUNK +: CHUNK]}
              - {1'b0, b_q[int'(k_q)*CHUNK +: CHUNK]}
              - (CHUNK+1)'(brw_q);
  end

  // Next-state logic. Output registers are only loaded on the last chunk so
  // they hold the previous result while a new operation is in progress.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    brw_d    = brw_q;
    k_d      = k_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          brw_d   = borrow_in;
          k_d     = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        res_d[int'(k_q)*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
        brw_d = chunk_res[CHUNK];
        k_d   = k_q + 1'b1;
        if (last_chunk) begin
          diff_d   = res_d;
          borrow_d = chunk_res[CHUNK];
          zero_d   = (res_d == '0);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      brw_q    <= 1'b0;
      k_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      brw_q    <= brw_d;
      k_q      <= k_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_multicycle_subtractor.sv
// Bench for multicycle_subtractor: 16/4 vector table, random vs model,
// back-pressure and mid-operation reset, plus exhaustive 4/1 and 4/4.
module tb_multicycle_subtractor;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // 16-bit / 4-bit chunk instance
  logic        iv, ir, ov, ordy, bin, bo, z;
  logic [15:0] a, b, d;
  // 4-bit instances (shared inputs)
  logic        iv4, ordy4, bin4;
  logic [3:0]  a4, b4;
  logic        ir41, ov41, bo41, z41, ir44, ov44, bo44, z44;
  logic [3:0]  d41, d44;

  multicycle_subtractor #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
    .borrow_in(bin), .out_valid(ov), .out_ready(ordy), .diff(d),
    .borrow(bo), .zero(z));
  multicycle_subtractor #(.WIDTH(4), .CHUNK(1)) dut41 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir41), .a(a4), .b(b4),
    .borrow_in(bin4), .out_valid(ov41), .out_ready(ordy4), .diff(d41),
    .borrow(bo41), .zero(z41));
  multicycle_subtractor #(.WIDTH(4), .CHUNK(4)) dut44 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir44), .a(a4), .b(b4),
    .borrow_in(bin4), .out_valid(ov44), .out_ready(ordy4), .diff(d44),
    .borrow(bo44), .zero(z44));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the full operands.
  function automatic void ref_sub(input int w, input longint ra, input longint rb,
                                  input int rbin, output longint rd, output int rbo);
    longint r;
    r   = ra - rb - rbin;
    rbo = (r < 0) ? 1 : 0;
    rd  = r & ((64'd1 << w) - 1);
  endfunction

  // Present operands to the 16-bit DUT, wait for the result.
  // lat counts cycles with the accepting cycle as cycle 0.
  task automatic run16(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                       output logic [15:0] rd, output logic rbo, output logic rz,
                       output int lat);
    a = ta; b = tb_; bin = tbin; iv = 1'b1; ordy = 1'b1;
    @(posedge clk); #1;
    iv  = 1'b0;
    lat = 1;
    while (!ov && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = d; rbo = bo; rz = z;
    @(posedge clk); #1;   // output handshake
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        bin;
    logic [15:0] ed;
    logic        ebo, ez;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [15:0] rd;
    logic        rbo, rz;
    int          lat;
    longint      md;
    int          mbo;
    logic [15:0] ra, rb, bd;
    logic        rbi, bbo, bz;

    vt[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vt[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vt[2] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b1};
    vt[4] = '{16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0};
    vt[5] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1};

    rst_n = 1'b0; iv = 0; ordy = 1; a = 0; b = 0; bin = 0;
    iv4 = 0; ordy4 = 1; a4 = 0; b4 = 0; bin4 = 0;
    #1;
    chk("rst in_ready", ir, 1);
    chk("rst out_valid", ov, 0);
    chk("rst diff", d, 0);
    chk("rst borrow", bo, 0);
    chk("rst zero", z, 0);
    #20; @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      run16(vt[i].a, vt[i].b, vt[i].bin, rd, rbo, rz, lat);
      chk($sformatf("vec%0d diff", i), rd, vt[i].ed);
      chk($sformatf("vec%0d borrow", i), rbo, vt[i].ebo);
      chk($sformatf("vec%0d zero", i), rz, vt[i].ez);
      chk($sformatf("vec%0d latency", i), lat, 5);
    end

    // Random vs model
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rbi = 1'($urandom_range(0, 1));
      if (i % 8 == 0) rb = ra;
      run16(ra, rb, rbi, rd, rbo, rz, lat);
      ref_sub(16, ra, rb, rbi, md, mbo);
      chk("rand diff", rd, md);
      chk("rand borrow", rbo, mbo);
      chk("rand zero", rz, (md == 0));
    end

    // Back-pressure: hold out_ready low with a second operand set waiting
    a = 16'h9000; b = 16'h1234; bin = 1'b0; iv = 1'b1; ordy = 1'b0;
    @(posedge clk); #1;
    a = 16'h0777; b = 16'h0700; bin = 1'b1;   // second set, must wait
    lat = 1;
    while (!ov && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("bp latency", lat, 5);
    for (int c = 0; c < 6; c++) begin
      chk("bp out_valid held", ov, 1);
      chk("bp in_ready low", ir, 0);
      chk("bp diff held", d, 16'h7DCC);
      chk("bp borrow held", bo, 0);
      @(posedge clk); #1;
    end
    ordy = 1'b1;
    @(posedge clk); #1;                 // output handshake
    chk("bp after hs in_ready", ir, 1);
    chk("bp after hs out_valid", ov, 0);
    @(posedge clk); #1;                 // second set accepted here
    chk("bp second accepted", ir, 0);
    iv = 1'b0;
    a = 16'hFFFF; b = 16'h0000; bin = 1'b0; // late changes must not matter
    lat = 1;
    while (!ov && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("bp second latency", lat, 5);
    chk("bp second diff", d, 16'h0076);
    chk("bp second borrow", bo, 0);
    @(posedge clk); #1;

    // Reset while chunk 2 is being computed
    a = 16'h4321; b = 16'h1111; bin = 1'b0; iv = 1'b1; ordy = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid busy in_ready", ir, 0);
    rst_n = 1'b0; #1;
    chk("rst mid diff", d, 0);
    chk("rst mid borrow", bo, 0);
    chk("rst mid zero", z, 0);
    chk("rst mid in_ready", ir, 1);
    chk("rst mid out_valid", ov, 0);
    @(negedge clk); rst_n = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 12; c++) begin
        @(posedge clk); #1;
        if (ov) seen++;
      end
      chk("no out_valid after reset", seen, 0);
    end

    // Exhaustive 4-bit: CHUNK=1 and CHUNK=4 in lockstep
    for (int i = 0; i < 512; i++) begin
      int c, l41, l44;
      logic [3:0] r41, r44;
      logic rb41, rb44;
      a4 = 4'(i); b4 = 4'(i >> 4); bin4 = 1'(i >> 8); iv4 = 1'b1;
      @(posedge clk); #1;
      iv4 = 1'b0;
      c = 1; l41 = 0; l44 = 0; r41 = 0; r44 = 0; rb41 = 0; rb44 = 0;
      while ((l41 == 0 || l44 == 0) && c < 20) begin
        if (ov41 && l41 == 0) begin l41 = c; r41 = d41; rb41 = bo41; end
        if (ov44 && l44 == 0) begin l44 = c; r44 = d44; rb44 = bo44; end
        if (l41 == 0 || l44 == 0) begin @(posedge clk); #1; c++; end
      end
      ref_sub(4, a4, b4, bin4, md, mbo);
      chk("ex41 diff", r41, md);
      chk("ex41 borrow", rb41, mbo);
      chk("ex41 latency", l41, 5);
      chk("ex44 diff", r44, md);
      chk("ex44 borrow", rb44, mbo);
      chk("ex44 latency", l44, 2);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
